vfu_result_wb_arbiter: RTL and testbench
========================================

Name: vfu_result_wb_arbiter

Overview:
- Per-lane responder for the functional-unit result write interface. Both the ALU and the MFPU drive this interface with req/id/addr/wdata/be and wait for gnt.
- Accepts results from both units into one-entry holding buffers and arbitrates them round-robin onto the single lane VRF write port.
- Respects per-bank busy indications from the operand requester.
- Sits between vector_fus_stage result outputs and the lane VRF.

Parameters:
- NrBanks, 8, number of VRF banks; power of two, ≥2.
- AddrWidth, 10, width of the VRF word address (vaddr_t bits).
- DataWidth, 64, result data width (elen_t bits).
- IdWidth, 3, width of the instruction id (vid_t bits).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- alu_result_req_i  in  1  ALU result request; held until granted
- alu_result_id_i  in  IdWidth  ALU instruction id
- alu_result_addr_i  in  AddrWidth  ALU destination word address
- alu_result_wdata_i  in  DataWidth  ALU result data
- alu_result_be_i  in  DataWidth/8  ALU byte enables
- alu_result_gnt_o  out  1  ALU grant; one-cycle acknowledge
- mfpu_result_req_i/id_i/addr_i/wdata_i/be_i  in  same widths  MFPU equivalents
- mfpu_result_gnt_o  out  1  MFPU grant
- vrf_bank_busy_i  in  NrBanks  bank is read this cycle; no write allowed to it
- vrf_we_o  out  1  VRF write strobe (registered)
- vrf_addr_o  out  AddrWidth  write address
- vrf_wdata_o  out  DataWidth  write data
- vrf_be_o  out  DataWidth/8  write byte enables
- vrf_id_o  out  IdWidth  id of the written instruction

Behaviour:
- Reset (rst_i high, asynchronous):
  - Both buffers invalid; RR pointer = ALU.
  - vrf_we_o=0; vrf_addr/wdata/be/id=0; gnt outputs=0 (combinational from empty buffers and no req).
- Bank select: bank(x) = addr[$clog2(NrBanks)-1:0].
- Per-source buffer (src ∈ {ALU, MFPU}): valid bit plus id/addr/wdata/be.
  - gnt_src = req_src & (!buf_valid_src | sel_src), combinational.
  - On gnt the buffer loads the request fields at the clock edge.
  - The buffer clears when selected with no simultaneous gnt.
- Eligibility: elig_src = buf_valid_src & !vrf_bank_busy_i[bank(buf_addr_src)].
- Selection, at most one write per cycle:
  - Only one eligible: select it.
  - Both eligible: select the RR pointer; pointer flips to the other source after that selection.
  - Pointer changes only on a contended selection.
- Output register: at the edge after selection, vrf_we_o=1 with the selected fields. vrf_we_o=0 when nothing is selected; data outputs then hold their last value.
- Latency: req at cycle N with empty buffer → gnt in N → write strobe in N+2 if the bank is free in N+1.
- Throughput: a single streaming source gets 1 result/cycle; two contending sources get 1/2 each. A buffered source never waits more than one contended cycle.
- Bank busy: a blocked buffer holds indefinitely. Its gnt stays low while req is high (backpressure). The other source proceeds independently.
- Same-address results from both sources in the same cycle: write order follows the RR pointer. Ordering across sources is not the arbiter's concern; the sequencer guarantees no WAW between FUs.
- req deasserted while the buffer is full: no effect; the buffered entry still drains.
- Reset mid-operation: buffered, unwritten results are discarded and the pending vrf_we_o pulse is cancelled. The FUs are reset alongside.

Optional Feature:
- Macro: VFU_WB_ARB_PERF_CNT_EN.
- Defined adds outputs:
  - alu_stall_cnt_o (32 bits): increments each cycle ALU req=1 and gnt=0.
  - mfpu_stall_cnt_o (32 bits): same for the MFPU.
  - bank_conflict_cnt_o (32 bits): increments each cycle any valid buffer is blocked by bank busy.
  - All counters saturate at all-ones and reset to 0.
- Undefined: ports and counters are absent; functional behaviour is identical.

Decomposition:
- In ara_pkg:
  - wb_src_e {WbSrcAlu=0, WbSrcMfpu=1}.
  - wb_entry_t packed struct {id, addr, wdata, be}.
  - function wb_bank(addr) returning the bank index.
- One sub-module, vfu_wb_buffer: a single-entry holding buffer with req/gnt in and valid/sel out. Instantiated twice; the arbiter top holds the RR pointer and output register.

Test Plan:
- ALU only, req with addr=0x012, wdata=0xDEAD_BEEF_0000_0001, be=0xFF, banks free → gnt same cycle; vrf_we_o=1 two cycles later with identical fields; back-to-back reqs give one write per cycle.
- Both sources stream 8 results each to distinct free banks → writes alternate ALU, MFPU, ALU…; 16 writes in 16 cycles after the pipeline fill of 2 cycles.
- ALU buffer addr=0x003 with vrf_bank_busy_i[3]=1 for 5 cycles → ALU gnt low while req held; MFPU continues writing; ALU write appears 1 cycle after busy drops.
- Single ALU req held for 1 cycle, bank free → the buffer selected in N+1 re-grants a new ALU req in the same cycle N+1 (gnt=1, no bubble).
- Assert rst_i for 1 cycle while both buffers are valid → vrf_we_o=0 next cycle, no stale write ever appears, pointer=ALU.
- With VFU_WB_ARB_PERF_CNT_EN: bank busy scenario above → bank_conflict_cnt_o=5, alu_stall_cnt_o=5 (stall cycles with req held).

Source files
------------

// File: rtl/vfu_result_wb_arbiter_pkg.sv
// Shared types and helpers for the per-lane functional-unit result write-back arbiter.
package vfu_result_wb_arbiter_pkg;

   // Default lane configuration.
   localparam int unsigned DefNrBanks   = 8;
   localparam int unsigned DefAddrWidth = 10;
   localparam int unsigned DefDataWidth = 64;
   localparam int unsigned DefIdWidth   = 3;

   // Result sources competing for the lane VRF write port.
   typedef enum logic {
      WbSrcAlu  = 1'b0,
      WbSrcMfpu = 1'b1
   } wb_src_e;

   // One pending result in the default configuration.
   typedef struct packed {
      logic [DefIdWidth-1:0]     id;
      logic [DefAddrWidth-1:0]   addr;
      logic [DefDataWidth-1:0]   wdata;
      logic [DefDataWidth/8-1:0] be;
   } wb_entry_t;

   // VRF bank addressed by a word address: its low log2(nr_banks) bits.
   function automatic int unsigned wb_bank(input logic [31:0] addr, input int unsigned nr_banks);
      return addr & (nr_banks - 1);
   endfunction

endpackage

// File: rtl/vfu_wb_buffer.sv
// Single-entry holding buffer for one result source: accepts a request when empty
// or when its current entry is being written out in the same cycle.
module vfu_wb_buffer #(
   parameter type entry_t = logic
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   req_i,
   input  entry_t entry_i,
   input  logic   sel_i,
   output logic   gnt_o,
   output logic   valid_o,
   output entry_t entry_o
);

   // Accept while empty, or while the held entry drains this cycle (no bubble).
   assign gnt_o = req_i & (~valid_o | sel_i);

   // Occupancy: fill on grant, empty when drained without a refill.
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst_i) begin
         valid_o <= 1'b0;
      end else if (gnt_o) begin
         valid_o <= 1'b1;
      end else if (sel_i) begin
         valid_o <= 1'b0;
      end
   end

   // Payload capture on grant.
   always_ff @(posedge clk_i) begin
      // NOTE: the payload has no reset; valid_o qualifies it, so reset only costs area here.
      if (gnt_o) begin
         entry_o <= entry_i;
      end
   end

endmodule

// File: rtl/vfu_result_wb_arbiter.sv
// Per-lane result write-back arbiter: buffers ALU and MFPU results one deep each and
// round-robins them onto the single VRF write port, skipping buffers whose bank is busy.
// Optional stall/conflict counters are built when VFU_WB_ARB_PERF_CNT_EN is defined.
module vfu_result_wb_arbiter
   import vfu_result_wb_arbiter_pkg::*;
#(
   parameter int unsigned NrBanks   = DefNrBanks,
   parameter int unsigned AddrWidth = DefAddrWidth,
   parameter int unsigned DataWidth = DefDataWidth,
   parameter int unsigned IdWidth   = DefIdWidth
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   alu_result_req_i,
   input  logic [IdWidth-1:0]     alu_result_id_i,
   input  logic [AddrWidth-1:0]   alu_result_addr_i,
   input  logic [DataWidth-1:0]   alu_result_wdata_i,
   input  logic [DataWidth/8-1:0] alu_result_be_i,
   output logic                   alu_result_gnt_o,
   input  logic                   mfpu_result_req_i,
   input  logic [IdWidth-1:0]     mfpu_result_id_i,
   input  logic [AddrWidth-1:0]   mfpu_result_addr_i,
   input  logic [DataWidth-1:0]   mfpu_result_wdata_i,
   input  logic [DataWidth/8-1:0] mfpu_result_be_i,
   output logic                   mfpu_result_gnt_o,
   input  logic [NrBanks-1:0]     vrf_bank_busy_i,
   output logic                   vrf_we_o,
   output logic [AddrWidth-1:0]   vrf_addr_o,
   output logic [DataWidth-1:0]   vrf_wdata_o,
   output logic [DataWidth/8-1:0] vrf_be_o,
   output logic [IdWidth-1:0]     vrf_id_o
`ifdef VFU_WB_ARB_PERF_CNT_EN
   ,
   output logic [31:0]            alu_stall_cnt_o,
   output logic [31:0]            mfpu_stall_cnt_o,
   output logic [31:0]            bank_conflict_cnt_o
`endif
);

   localparam int unsigned BankBits = $clog2(NrBanks);

   typedef struct packed {
      logic [IdWidth-1:0]     id;
      logic [AddrWidth-1:0]   addr;
      logic [DataWidth-1:0]   wdata;
      logic [DataWidth/8-1:0] be;
   } entry_t;

   entry_t              alu_in, mfpu_in, alu_buf, mfpu_buf, out_q;
   logic                alu_valid, mfpu_valid;
   logic                alu_elig, mfpu_elig;
   logic                alu_sel, mfpu_sel;
   logic [BankBits-1:0] alu_bank, mfpu_bank;
   wb_src_e             rr_q;
   logic                we_q;

   assign alu_in  = '{id: alu_result_id_i, addr: alu_result_addr_i,
                      wdata: alu_result_wdata_i, be: alu_result_be_i};
   assign mfpu_in = '{id: mfpu_result_id_i, addr: mfpu_result_addr_i,
                      wdata: mfpu_result_wdata_i, be: mfpu_result_be_i};

   vfu_wb_buffer #(.entry_t(entry_t)) i_alu_buf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (alu_result_req_i),
      .entry_i (alu_in),
      .sel_i   (alu_sel),
      .gnt_o   (alu_result_gnt_o),
      .valid_o (alu_valid),
      .entry_o (alu_buf)
   );

   vfu_wb_buffer #(.entry_t(entry_t)) i_mfpu_buf (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .req_i   (mfpu_result_req_i),
      .entry_i (mfpu_in),
      .sel_i   (mfpu_sel),
      .gnt_o   (mfpu_result_gnt_o),
      .valid_o (mfpu_valid),
      .entry_o (mfpu_buf)
   );

   assign alu_bank  = BankBits'(wb_bank(32'(alu_buf.addr), NrBanks));
   assign mfpu_bank = BankBits'(wb_bank(32'(mfpu_buf.addr), NrBanks));
   assign alu_elig  = alu_valid & ~vrf_bank_busy_i[alu_bank];
   assign mfpu_elig = mfpu_valid & ~vrf_bank_busy_i[mfpu_bank];

   // Pick at most one eligible buffer; contention is broken by the round-robin pointer.
   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      alu_sel  = 1'b0;
      mfpu_sel = 1'b0;
      if (alu_elig && mfpu_elig) begin
         alu_sel  = (rr_q == WbSrcAlu);
         mfpu_sel = (rr_q == WbSrcMfpu);
      end else begin
         alu_sel  = alu_elig;
         mfpu_sel = mfpu_elig;
      end
   end

   // Round-robin pointer: hand priority to the loser after every contended pick.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q <= WbSrcAlu;
      end else if (alu_elig && mfpu_elig) begin
         rr_q <= (rr_q == WbSrcAlu) ? WbSrcMfpu : WbSrcAlu;
      end
   end

   // Registered VRF write port; data holds its last value when no write is issued.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q  <= 1'b0;
         out_q <= '0;
      end else begin
         we_q <= alu_sel | mfpu_sel;
         if (alu_sel) begin
            out_q <= alu_buf;
         end else if (mfpu_sel) begin
            out_q <= mfpu_buf;
         end
      end
   end

   assign vrf_we_o    = we_q;
   assign vrf_addr_o  = out_q.addr;
   assign vrf_wdata_o = out_q.wdata;
   assign vrf_be_o    = out_q.be;
   assign vrf_id_o    = out_q.id;

`ifdef VFU_WB_ARB_PERF_CNT_EN
   logic alu_stall, mfpu_stall, bank_conflict;

   assign alu_stall     = alu_result_req_i & ~alu_result_gnt_o;
   assign mfpu_stall    = mfpu_result_req_i & ~mfpu_result_gnt_o;
   assign bank_conflict = (alu_valid & ~alu_elig) | (mfpu_valid & ~mfpu_elig);

   // Saturating event counters.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         alu_stall_cnt_o     <= '0;
         mfpu_stall_cnt_o    <= '0;
         bank_conflict_cnt_o <= '0;
      end else begin
         if (alu_stall && (alu_stall_cnt_o != '1)) begin
            alu_stall_cnt_o <= alu_stall_cnt_o + 32'd1;
         end
         if (mfpu_stall && (mfpu_stall_cnt_o != '1)) begin
            mfpu_stall_cnt_o <= mfpu_stall_cnt_o + 32'd1;
         end
         if (bank_conflict && (bank_conflict_cnt_o != '1)) begin
            bank_conflict_cnt_o <= bank_conflict_cnt_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vfu_result_wb_arbiter.sv
// Self-checking bench for vfu_result_wb_arbiter: randomized and directed traffic,
// a transaction-level reference model, and a scoreboard monitor on the VRF write port.
module tb_vfu_result_wb_arbiter;
   import vfu_result_wb_arbiter_pkg::*;

   localparam int unsigned NB = DefNrBanks;
   localparam int unsigned BB = $clog2(NB);
   localparam int unsigned AW = DefAddrWidth;
   localparam int unsigned DW = DefDataWidth;
   localparam int unsigned IW = DefIdWidth;

   typedef struct {
      wb_entry_t   e;
      int unsigned cyc;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_req, mfpu_req, alu_gnt, mfpu_gnt;
   logic [IW-1:0]   alu_id, mfpu_id, vrf_id;
   logic [AW-1:0]   alu_addr, mfpu_addr, vrf_addr;
   logic [DW-1:0]   alu_wdata, mfpu_wdata, vrf_wdata;
   logic [DW/8-1:0] alu_be, mfpu_be, vrf_be;
   logic [NB-1:0]   busy;
   logic            vrf_we;
`ifdef VFU_WB_ARB_PERF_CNT_EN
   logic [31:0]     alu_stall_cnt, mfpu_stall_cnt, bank_conflict_cnt;
   int unsigned     m_alu_stall, m_mfpu_stall, m_conflict;
`endif

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned edge_cnt = 0;
   exp_t        exp_q[$];

   // Reference model: per-source holding slot and the priority owner (0 = ALU, 1 = MFPU).
   logic        m_valid[2];
   wb_entry_t   m_ent[2];
   int          m_rr;

   // Functional-unit side: a pending request holds its fields until granted.
   logic        p_req[2];
   wb_entry_t   p_ent[2];

   always #5 clk = ~clk;

   vfu_result_wb_arbiter dut (
      .clk_i               (clk),
      .rst_i               (rst),
      .alu_result_req_i    (alu_req),
      .alu_result_id_i     (alu_id),
      .alu_result_addr_i   (alu_addr),
      .alu_result_wdata_i  (alu_wdata),
      .alu_result_be_i     (alu_be),
      .alu_result_gnt_o    (alu_gnt),
      .mfpu_result_req_i   (mfpu_req),
      .mfpu_result_id_i    (mfpu_id),
      .mfpu_result_addr_i  (mfpu_addr),
      .mfpu_result_wdata_i (mfpu_wdata),
      .mfpu_result_be_i    (mfpu_be),
      .mfpu_result_gnt_o   (mfpu_gnt),
      .vrf_bank_busy_i     (busy),
      .vrf_we_o            (vrf_we),
      .vrf_addr_o          (vrf_addr),
      .vrf_wdata_o         (vrf_wdata),
      .vrf_be_o            (vrf_be),
      .vrf_id_o            (vrf_id)
`ifdef VFU_WB_ARB_PERF_CNT_EN
      ,
      .alu_stall_cnt_o     (alu_stall_cnt),
      .mfpu_stall_cnt_o    (mfpu_stall_cnt),
      .bank_conflict_cnt_o (bank_conflict_cnt)
`endif
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic wb_entry_t rand_entry(input int bank);
      wb_entry_t e;
      e.id    = IW'($urandom);
      e.addr  = AW'($urandom);
      e.wdata = {$urandom, $urandom};
      e.be    = (DW/8)'($urandom);
      if (bank >= 0) e.addr = AW'((int'(e.addr) / NB) * NB + bank);
      return e;
   endfunction

   function automatic logic bank_busy(input logic [NB-1:0] b, input wb_entry_t e);
      logic [BB-1:0] idx;
      idx = BB'(int'(e.addr) % NB);
      return b[idx];
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < 2; s++) begin
         m_valid[s] = 1'b0;
         p_req[s]   = 1'b0;
      end
      m_rr = 0;
`ifdef VFU_WB_ARB_PERF_CNT_EN
      m_alu_stall  = 0;
      m_mfpu_stall = 0;
      m_conflict   = 0;
`endif
   endfunction

   // One clock cycle: drive pending requests and bank busy, predict grants and the write.
   task automatic step(input logic [NB-1:0] b);
      logic el[2];
      logic g[2];
      int   pick;
      @(negedge clk);
      alu_req    = p_req[0];
      alu_id     = p_ent[0].id;
      alu_addr   = p_ent[0].addr;
      alu_wdata  = p_ent[0].wdata;
      alu_be     = p_ent[0].be;
      mfpu_req   = p_req[1];
      mfpu_id    = p_ent[1].id;
      mfpu_addr  = p_ent[1].addr;
      mfpu_wdata = p_ent[1].wdata;
      mfpu_be    = p_ent[1].be;
      busy       = b;
      #1;
`ifdef VFU_WB_ARB_PERF_CNT_EN
      check("alu_stall_cnt", 128'(alu_stall_cnt), 128'(m_alu_stall));
      check("mfpu_stall_cnt", 128'(mfpu_stall_cnt), 128'(m_mfpu_stall));
      check("bank_conflict_cnt", 128'(bank_conflict_cnt), 128'(m_conflict));
`endif
      for (int s = 0; s < 2; s++) el[s] = m_valid[s] && !bank_busy(b, m_ent[s]);
      pick = -1;
      if (el[0] && el[1]) begin
         pick = m_rr;
         m_rr = 1 - m_rr;
      end else if (el[0]) pick = 0;
      else if (el[1]) pick = 1;
      for (int s = 0; s < 2; s++) g[s] = p_req[s] && (!m_valid[s] || pick == s);
      check("alu_gnt", 128'(alu_gnt), 128'(g[0]));
      check("mfpu_gnt", 128'(mfpu_gnt), 128'(g[1]));
      if (pick >= 0) exp_q.push_back('{e: m_ent[pick], cyc: edge_cnt + 1});
`ifdef VFU_WB_ARB_PERF_CNT_EN
      if (p_req[0] && !g[0]) m_alu_stall++;
      if (p_req[1] && !g[1]) m_mfpu_stall++;
      if ((m_valid[0] && !el[0]) || (m_valid[1] && !el[1])) m_conflict++;
`endif
      for (int s = 0; s < 2; s++) begin
         if (g[s]) begin
            m_valid[s] = 1'b1;
            m_ent[s]   = p_ent[s];
            p_req[s]   = 1'b0;
         end else if (pick == s) begin
            m_valid[s] = 1'b0;
         end
      end
   endtask

   // Reset for one cycle mid-operation: buffered results are dropped, no write may follow.
   task automatic do_reset();
      @(negedge clk);
      rst      = 1'b1;
      alu_req  = 1'b0;
      mfpu_req = 1'b0;
      #1;
      check("rst_vrf_we", 128'(vrf_we), 128'(0));
      check("rst_vrf_fields", {43'b0, vrf_id, vrf_addr, vrf_wdata, vrf_be}, 128'(0));
      check("rst_alu_gnt", 128'(alu_gnt), 128'(0));
      check("rst_mfpu_gnt", 128'(mfpu_gnt), 128'(0));
      model_reset();
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Scoreboard monitor: one sample per cycle, after the edge has settled.
   initial begin
      exp_t e;
      logic due;
      forever begin
         @(posedge clk);
         #1;
         edge_cnt++;
         due = (exp_q.size() > 0) && (exp_q[0].cyc == edge_cnt);
         check("vrf_we", 128'(vrf_we), 128'(due));
         if (due) begin
            e = exp_q.pop_front();
            if (vrf_we) check("vrf_write", {43'b0, vrf_id, vrf_addr, vrf_wdata, vrf_be}, 128'(e.e));
         end
      end
   end

   initial begin
      int issued[2];
      rst = 1'b1;
      alu_req = 1'b0; alu_id = '0; alu_addr = '0; alu_wdata = '0; alu_be = '0;
      mfpu_req = 1'b0; mfpu_id = '0; mfpu_addr = '0; mfpu_wdata = '0; mfpu_be = '0;
      busy = '0;
      model_reset();
      p_ent[0] = '0;
      p_ent[1] = '0;
      @(negedge clk);
      check("init_vrf_we", 128'(vrf_we), 128'(0));
      check("init_vrf_fields", {43'b0, vrf_id, vrf_addr, vrf_wdata, vrf_be}, 128'(0));
      check("init_alu_gnt", 128'(alu_gnt), 128'(0));
      check("init_mfpu_gnt", 128'(mfpu_gnt), 128'(0));
      rst = 1'b0;

      // ALU alone: first result lands two cycles after its grant, then back-to-back.
      p_req[0] = 1'b1;
      p_ent[0] = '{id: 3'd1, addr: 10'h012, wdata: 64'hDEAD_BEEF_0000_0001, be: 8'hFF};
      step('0);
      for (int i = 0; i < 4; i++) begin
         p_req[0] = 1'b1;
         p_ent[0] = rand_entry(i);
         step('0);
      end
      step('0);
      step('0);

      // Both units streaming 8 results each to distinct free banks.
      issued[0] = 0;
      issued[1] = 0;
      for (int c = 0; c < 40; c++) begin
         for (int s = 0; s < 2; s++) begin
            if (!p_req[s] && issued[s] < 8) begin
               p_req[s] = 1'b1;
               p_ent[s] = rand_entry(2 * (issued[s] % (NB / 2)) + s);
               issued[s]++;
            end
         end
         step('0);
      end

      // ALU blocked on bank 3 for five cycles while the MFPU keeps writing to bank 5.
      p_req[0] = 1'b1;
      p_ent[0] = rand_entry(3);
      step(NB'(8'h08));
      p_req[0] = 1'b1;
      p_ent[0] = rand_entry(3);
      for (int i = 0; i < 5; i++) begin
         if (!p_req[1]) begin
            p_req[1] = 1'b1;
            p_ent[1] = rand_entry(5);
         end
         step(NB'(8'h08));
      end
      for (int i = 0; i < 4; i++) step('0);

      // Reset while both buffers hold unwritten results, then contend: ALU must win first.
      for (int s = 0; s < 2; s++) begin
         p_req[s] = 1'b1;
         p_ent[s] = rand_entry(s);
      end
      step('1);
      for (int s = 0; s < 2; s++) begin
         p_req[s] = 1'b1;
         p_ent[s] = rand_entry(s);
      end
      step('1);
      do_reset();
      for (int s = 0; s < 2; s++) begin
         p_req[s] = 1'b1;
         p_ent[s] = rand_entry(-1);
      end
      step('0);
      step('0);
      step('0);

      // Randomized traffic with random bank busy and occasional withdrawn requests.
      for (int i = 0; i < 1500; i++) begin
         for (int s = 0; s < 2; s++) begin
            if (!p_req[s] && $urandom_range(0, 3) != 0) begin
               p_req[s] = 1'b1;
               p_ent[s] = rand_entry(-1);
            end else if (p_req[s] && $urandom_range(0, 31) == 0) begin
               p_req[s] = 1'b0;
            end
         end
         if (i == 700) do_reset();
         else step(NB'($urandom & $urandom));
      end

      // Drain everything still buffered.
      p_req[0] = 1'b0;
      p_req[1] = 1'b0;
      for (int i = 0; i < 4; i++) step('0);
      @(negedge clk);
      check("queue_drained", 128'(exp_q.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
